pipe_mem_arb: RTL and testbench

PIPE_MEM_ARB -- requirements
Module: pipe_mem_arb

---
 rtl/pipe_mem_pkg.sv | 14 +
 rtl/pipe_mem_arb_if.sv | 39 +++
 rtl/pipe_wait_cnt.sv | 26 ++
 rtl/pipe_mem_arb.sv | 123 ++++++++++++
 tb/tb_pipe_mem_arb.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared types and widths for the fetch/data memory arbiter slice.
package pipe_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_mem_arb_if.sv
// Bundle of fetch port, data port and shared memory port signals.
interface pipe_mem_arb_if;
    import pipe_mem_pkg::*;

    // Handshake: a requester raises *_req with stable address/data and holds it
    // until it sees the one-cycle *_ready pulse; *_rdata is valid in that cycle.
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              i_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              d_stall;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
               m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
               m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/pipe_wait_cnt.sv
// Loadable down-counter timing one memory access; zero marks the last cycle.
module pipe_wait_cnt
    import pipe_mem_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - CNT_W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pipe_mem_arb.sv
// Single-port memory arbiter between fetch and MEM stages.
// Define PIPE_MEM_ARB_RR_EN for round-robin ties; default is data-port priority.
module pipe_mem_arb
    import pipe_mem_pkg::*;
#(
    parameter int WAIT = 2
) (
    input  logic           clock,
    input  logic           reset,
    pipe_mem_arb_if.slave  bus,
    output state_t         state_dbg
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT - 1);

    state_t            state, state_next;
    logic              i_ready_q, d_ready_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
    logic              idle, i_elig, d_elig, grant_i, grant_d;
    logic              cnt_load, cnt_dec, cnt_zero;

    // A port in its ready cycle is masked so a held request is not re-served at once.
    assign idle   = (state == IDLE);
    assign i_elig = idle & bus.i_req & ~i_ready_q;
    assign d_elig = idle & bus.d_req & ~d_ready_q;

`ifdef PIPE_MEM_ARB_RR_EN
    logic last_d;

    assign grant_d = d_elig & (~i_elig | ~last_d);
    assign grant_i = i_elig & (~d_elig | last_d);

    always_ff @(posedge clock) begin
        if (reset)
            last_d <= 1'b0;
        else if (grant_i || grant_d)
            last_d <= grant_d;
    end
`else
    assign grant_d = d_elig;
    assign grant_i = i_elig & ~d_elig;
`endif

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                cnt_load = grant_i | grant_d;
                if (grant_d)
                    state_next = DACC;
                else if (grant_i)
                    state_next = IACC;
            end
            IACC, DACC: begin
                if (cnt_zero)
                    state_next = IDLE;
                else
                    cnt_dec = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    pipe_wait_cnt u_wait_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (LOAD_VAL),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_ready_q <= (state == IACC) & cnt_zero;
            d_ready_q <= (state == DACC) & cnt_zero;
            if (grant_d) begin
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
                we_q    <= bus.d_we;
            end else if (grant_i) begin
                addr_q  <= bus.i_addr;
                we_q    <= 1'b0;
            end
            if (state == IACC && cnt_zero)
                i_rdata_q <= bus.m_rdata;
            // Stores leave the load-data register untouched.
            if (state == DACC && cnt_zero && !we_q)
                d_rdata_q <= bus.m_rdata;
        end
    end

    assign bus.m_en    = ~idle;
    assign bus.m_we    = (state == DACC) & we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ready = i_ready_q;
    assign bus.d_ready = d_ready_q;
    assign bus.i_stall = bus.i_req & ~i_ready_q;
    assign bus.d_stall = bus.d_req & ~d_ready_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_pipe_mem_arb.sv
// Bench for pipe_mem_arb: three instances with WAIT = 1, 2, 3 behind a memory model.
module tb_pipe_mem_arb;
  import pipe_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        i_req_v[3];
  logic [31:0] i_addr_v[3];
  logic        d_req_v[3];
  logic        d_we_v[3];
  logic [31:0] d_addr_v[3];
  logic [31:0] d_wdata_v[3];
  logic [31:0] i_rdata_v[3];
  logic        i_ready_v[3];
  logic        i_stall_v[3];
  logic [31:0] d_rdata_v[3];
  logic        d_ready_v[3];
  logic        d_stall_v[3];
  logic        m_en_v[3];
  logic        m_we_v[3];
  logic [31:0] m_addr_v[3];
  logic [31:0] m_wdata_v[3];
  state_t      state_v[3];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h2002_0045;
  endfunction

  pipe_mem_arb_if bus[3] ();

  for (genvar k = 0; k < 3; k++) begin : g_dut
    pipe_mem_arb #(.WAIT(k + 1)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus[k]),
      .state_dbg (state_v[k])
    );
    assign bus[k].i_req   = i_req_v[k];
    assign bus[k].i_addr  = i_addr_v[k];
    assign bus[k].d_req   = d_req_v[k];
    assign bus[k].d_we    = d_we_v[k];
    assign bus[k].d_addr  = d_addr_v[k];
    assign bus[k].d_wdata = d_wdata_v[k];
    assign i_rdata_v[k]   = bus[k].i_rdata;
    assign i_ready_v[k]   = bus[k].i_ready;
    assign i_stall_v[k]   = bus[k].i_stall;
    assign d_rdata_v[k]   = bus[k].d_rdata;
    assign d_ready_v[k]   = bus[k].d_ready;
    assign d_stall_v[k]   = bus[k].d_stall;
    assign m_en_v[k]      = bus[k].m_en;
    assign m_we_v[k]      = bus[k].m_we;
    assign m_addr_v[k]    = bus[k].m_addr;
    assign m_wdata_v[k]   = bus[k].m_wdata;

    // Memory model: read data is only valid in the last (WAIT-th) enabled cycle.
    logic [3:0] acc_cnt;
    always @(posedge clock) begin
      if (reset || !bus[k].m_en) acc_cnt <= 4'd0;
      else                       acc_cnt <= acc_cnt + 4'd1;
    end
    assign bus[k].m_rdata = (bus[k].m_en && acc_cnt == 4'(k)) ? mem_f(bus[k].m_addr) : 32'hBAD0_0000;
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic access(input int k, input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                        output int en_cyc, output int we_cyc, output int addr_err, output int other_rdy);
    lat = 0; en_cyc = 0; we_cyc = 0; addr_err = 0; other_rdy = 0; rd = '0;
    @(posedge clock);
    @(negedge clock);
    if (is_d) begin
      d_req_v[k] = 1'b1; d_we_v[k] = we; d_addr_v[k] = addr; d_wdata_v[k] = wdata;
    end else begin
      i_req_v[k] = 1'b1; i_addr_v[k] = addr;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (m_en_v[k]) begin
        en_cyc++;
        if (m_we_v[k]) we_cyc++;
        if (m_addr_v[k] !== addr || (we && m_wdata_v[k] !== wdata)) addr_err++;
      end
      if (is_d ? i_ready_v[k] : d_ready_v[k]) other_rdy++;
      if (is_d ? d_ready_v[k] : i_ready_v[k]) begin
        lat = c;
        break;
      end
    end
    rd = is_d ? d_rdata_v[k] : i_rdata_v[k];
    i_req_v[k] = 1'b0; d_req_v[k] = 1'b0; d_we_v[k] = 1'b0;
  endtask

  task automatic tie_pair(input int k, input logic [31:0] ia, input logic [31:0] da,
                          output int i_t, output int d_t, output int both,
                          output logic [31:0] ird, output logic [31:0] drd,
                          output logic si1, output logic sd1);
    i_t = 0; d_t = 0; both = 0; ird = '0; drd = '0; si1 = 1'b0; sd1 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    i_req_v[k] = 1'b1; i_addr_v[k] = ia;
    d_req_v[k] = 1'b1; d_we_v[k] = 1'b0; d_addr_v[k] = da;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); #1;
      if (c == 1) begin si1 = i_stall_v[k]; sd1 = d_stall_v[k]; end
      if (i_ready_v[k] && d_ready_v[k]) both++;
      if (d_ready_v[k] && d_t == 0) begin d_t = c; drd = d_rdata_v[k]; d_req_v[k] = 1'b0; end
      if (i_ready_v[k] && i_t == 0) begin i_t = c; ird = i_rdata_v[k]; i_req_v[k] = 1'b0; end
      if (i_t != 0 && d_t != 0) break;
    end
    i_req_v[k] = 1'b0; d_req_v[k] = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          k;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_en;
    int          exp_we;
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    int lat, en_cyc, we_cyc, addr_err, other_rdy, i_t, d_t, both;
    logic [31:0] rd, ird, drd;
    logic si1, sd1;
    int kinds[$];
    int times[$];
    int cnt, rdy_cnt, stall_err, en_after, dbl, data_err;
    logic prev_rdy;

    vecs[0] = '{1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h2002_0005, 3, 2, 0};
    vecs[1] = '{1, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h2002_0145, 3, 2, 0};
    vecs[2] = '{1, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'h2002_0145, 3, 2, 2};
    vecs[3] = '{1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hDFFD_FFB9, 3, 2, 0};
    vecs[4] = '{1, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h2002_0045, 3, 2, 0};
    vecs[5] = '{1, 1'b1, 1'b1, 32'h0000_000C, 32'hA5A5_A5A5, 32'h2002_0045, 3, 2, 2};
    vecs[6] = '{2, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h2002_0055, 4, 3, 0};
    vecs[7] = '{2, 1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h2002_0055, 4, 3, 3};
    vecs[8] = '{0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h2002_0005, 2, 1, 0};

    for (int k = 0; k < 3; k++) begin
      i_req_v[k] = 1'b0; i_addr_v[k] = '0; d_req_v[k] = 1'b0;
      d_we_v[k] = 1'b0; d_addr_v[k] = '0; d_wdata_v[k] = '0;
    end
    do_reset();

    // reset state
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_state[%0d]", k), 32'(state_v[k]), 32'(IDLE));
      check($sformatf("rst_m_en[%0d]", k), 32'(m_en_v[k]), 32'd0);
      check($sformatf("rst_m_we[%0d]", k), 32'(m_we_v[k]), 32'd0);
      check($sformatf("rst_readies[%0d]", k), {30'd0, i_ready_v[k], d_ready_v[k]}, 32'd0);
      check($sformatf("rst_m_addr[%0d]", k), m_addr_v[k], 32'd0);
      check($sformatf("rst_m_wdata[%0d]", k), m_wdata_v[k], 32'd0);
      check($sformatf("rst_i_rdata[%0d]", k), i_rdata_v[k], 32'd0);
      check($sformatf("rst_d_rdata[%0d]", k), d_rdata_v[k], 32'd0);
    end

    // simultaneous requests right after reset: data first in both builds
    tie_pair(1, 32'h0000_0300, 32'h0000_0100, i_t, d_t, both, ird, drd, si1, sd1);
    check("tie0_d_time", d_t, 3);
    check("tie0_i_time", i_t, 6);
    check("tie0_both_ready", both, 0);
    check("tie0_d_rdata", drd, 32'h2002_0145);
    check("tie0_i_rdata", ird, 32'h2002_0345);
    check("tie0_i_stall", 32'(si1), 32'd1);
    check("tie0_d_stall", 32'(sd1), 32'd1);

    // table of single transactions
    for (int v = 0; v < 9; v++) begin
      access(vecs[v].k, vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
             lat, rd, en_cyc, we_cyc, addr_err, other_rdy);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
      check($sformatf("v%0d_en_cycles", v), en_cyc, vecs[v].exp_en);
      check($sformatf("v%0d_we_cycles", v), we_cyc, vecs[v].exp_we);
      check($sformatf("v%0d_addr_wdata", v), addr_err, 0);
      check($sformatf("v%0d_other_ready", v), other_rdy, 0);
    end

    // tie after a data grant: round-robin serves fetch first, fixed priority data
    tie_pair(1, 32'h0000_0044, 32'h0000_0104, i_t, d_t, both, ird, drd, si1, sd1);
`ifdef PIPE_MEM_ARB_RR_EN
    check("tie1_i_time", i_t, 3);
    check("tie1_d_time", d_t, 6);
`else
    check("tie1_d_time", d_t, 3);
    check("tie1_i_time", i_t, 6);
`endif
    check("tie1_i_rdata", ird, 32'h2002_0001);
    check("tie1_d_rdata", drd, 32'h2002_0141);
    check("tie1_both_ready", both, 0);

    // both requests held continuously from reset: D,I,D,I every WAIT+1 cycles
    do_reset();
    @(negedge clock);
    i_req_v[1] = 1'b1; i_addr_v[1] = 32'h0000_0040;
    d_req_v[1] = 1'b1; d_we_v[1] = 1'b0; d_addr_v[1] = 32'h0000_0100;
    both = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clock); #1;
      if (i_ready_v[1] && d_ready_v[1]) both++;
      if (d_ready_v[1]) begin kinds.push_back(1); times.push_back(c); end
      if (i_ready_v[1]) begin kinds.push_back(0); times.push_back(c); end
      if (c == 12) begin i_req_v[1] = 1'b0; d_req_v[1] = 1'b0; end
    end
    cnt = kinds.size();
    check("alt_pulses", cnt, 4);
    check("alt_both_ready", both, 0);
    for (int p = 0; p < 4 && p < cnt; p++) begin
      check($sformatf("alt_kind%0d", p), kinds[p], (p % 2 == 0) ? 1 : 0);
      check($sformatf("alt_time%0d", p), times[p], 3 * (p + 1));
    end

    // reset in the second DACC cycle aborts the access
    @(posedge clock);
    @(negedge clock);
    d_req_v[1] = 1'b1; d_we_v[1] = 1'b0; d_addr_v[1] = 32'h0000_0100;
    @(posedge clock); #1;
    check("abort_dacc1", 32'(state_v[1]), 32'(DACC));
    @(posedge clock); #1;
    check("abort_dacc2", 32'(state_v[1]), 32'(DACC));
    reset = 1'b1;
    d_req_v[1] = 1'b0;
    @(posedge clock); #1;
    check("abort_state", 32'(state_v[1]), 32'(IDLE));
    check("abort_m_en", 32'(m_en_v[1]), 32'd0);
    check("abort_d_ready", 32'(d_ready_v[1]), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (d_ready_v[1]) cnt++;
    end
    check("abort_no_ready", cnt, 0);
    access(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, lat, rd, en_cyc, we_cyc, addr_err, other_rdy);
    check("reissue_latency", lat, 3);
    check("reissue_rdata", rd, 32'h2002_0145);

    // WAIT=1, fetch held: ready every third cycle, never re-granted in a ready cycle
    @(posedge clock);
    @(negedge clock);
    i_req_v[0] = 1'b1; i_addr_v[0] = 32'h0000_0040;
    rdy_cnt = 0; stall_err = 0; en_after = 0; dbl = 0; data_err = 0; prev_rdy = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock); #1;
      if (i_stall_v[0] !== ~i_ready_v[0]) stall_err++;
      if (prev_rdy && m_en_v[0]) en_after++;
      if (prev_rdy && i_ready_v[0]) dbl++;
      if (i_ready_v[0]) begin
        rdy_cnt++;
        if (i_rdata_v[0] !== 32'h2002_0005) data_err++;
      end
      prev_rdy = i_ready_v[0];
    end
    i_req_v[0] = 1'b0;
    check("w1_ready_count", rdy_cnt, 4);
    check("w1_stall_vs_ready", stall_err, 0);
    check("w1_grant_in_ready", en_after, 0);
    check("w1_double_pulse", dbl, 0);
    check("w1_rdata", data_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
